dcache_controller: RTL and testbench

//   Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and data memory.

---
 rtl/dcache_controller.sv | 109 ++++++++++
 tb/tb_dcache_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes, 8-bit byte address.
// Hits finish in the issuing cycle. A miss stalls the CPU while a dirty victim block is written
// back and/or the missing block is fetched from memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serving hits; a miss leaves at the next rising edge
// WRITEBACK | dirty victim block going out to memory (write_mem high)
// FETCH     | missing block coming in from memory (read_mem high)
module dcache_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        read_mem,
    output logic        write_mem,
    output logic [5:0]  address_mem,
    output logic [31:0] writedata_mem,
    input  logic [31:0] readdata_mem,
    input  logic        busywait_mem
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t      state;
    logic [31:0] data_arr [8];
    logic [2:0]  tag_arr  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;

    logic [2:0]  tag;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic        hit;

    assign tag    = address[7:5];
    assign index  = address[4:2];
    assign offset = address[1:0];
    assign hit    = valid[index] && (tag_arr[index] == tag);

    // Selected byte always driven; it is only meaningful on a read hit.
    assign readdata = data_arr[index][{offset, 3'b000} +: 8];

    // Stall the CPU on any miss in IDLE and for the whole of a memory transaction.
    always_comb begin
        busywait = 1'b0;
        if (state == IDLE) busywait = (read || write) && !hit;
        else               busywait = 1'b1;
    end

    // FSM, registered memory strobes/bus, and cache line storage.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            read_mem      <= 1'b0;
            write_mem     <= 1'b0;
            address_mem   <= '0;
            writedata_mem <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write has priority over a simultaneous read.
                    if (write && hit) begin
                        data_arr[index][{offset, 3'b000} +: 8] <= writedata;
                        dirty[index] <= 1'b1;
                    end else if ((read || write) && !hit) begin
                        if (valid[index] && dirty[index]) begin
                            state         <= WRITEBACK;
                            write_mem     <= 1'b1;
                            address_mem   <= {tag_arr[index], index};
                            writedata_mem <= data_arr[index];
                        end else begin
                            state       <= FETCH;
                            read_mem    <= 1'b1;
                            address_mem <= address[7:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!busywait_mem) begin
                        state       <= FETCH;
                        write_mem   <= 1'b0;
                        read_mem    <= 1'b1;
                        address_mem <= address[7:2];
                    end
                end
                FETCH: begin
                    if (!busywait_mem) begin
                        state           <= IDLE;
                        read_mem        <= 1'b0;
                        address_mem     <= '0;
                        data_arr[index] <= readdata_mem;
                        tag_arr[index]  <= tag;
                        valid[index]    <= 1'b1;
                        dirty[index]    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller. The memory is a simple model: busywait_mem follows the
// strobes combinationally until the bench sets mem_ack, which completes the transaction.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        read, write;
    logic [7:0]  address, writedata;
    logic [7:0]  readdata;
    logic        busywait, read_mem, write_mem;
    logic [5:0]  address_mem;
    logic [31:0] writedata_mem, readdata_mem;
    logic        busywait_mem;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign busywait_mem = (read_mem || write_mem) && !mem_ack;

    dcache_controller dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .read_mem(read_mem), .write_mem(write_mem),
        .address_mem(address_mem), .writedata_mem(writedata_mem),
        .readdata_mem(readdata_mem), .busywait_mem(busywait_mem)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        readdata_mem = '0; mem_ack = 1'b0;
        #2;
        RESET = 1'b0;
        tick();
        check("rst_read_mem", read_mem, 1'b0);
        check("rst_write_mem", write_mem, 1'b0);
        check("rst_busywait", busywait, 1'b0);
        check("rst_address_mem", address_mem, 6'h00);
        check("rst_writedata_mem", writedata_mem, 32'h0);
        RESET = 1'b1;

        // Read miss on invalid line 1
        read = 1'b1; address = 8'h05; #1;
        check("miss_busywait", busywait, 1'b1);
        check("miss_no_strobe_idle", read_mem, 1'b0);
        tick();
        check("fetch_read_mem", read_mem, 1'b1);
        check("fetch_addr", address_mem, 6'h01);
        check("fetch_write_mem", write_mem, 1'b0);
        tick();
        check("fetch_hold_while_busy", read_mem, 1'b1);
        check("fetch_busywait_held", busywait, 1'b1);
        readdata_mem = 32'hDDCCBBAA; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
        check("fill_read_mem_drop", read_mem, 1'b0);
        check("fill_busywait", busywait, 1'b0);
        check("fill_readdata", readdata, 8'hBB);

        // Write hit then read back
        read = 1'b0; write = 1'b1; address = 8'h06; writedata = 8'h5A; #1;
        check("whit_busywait", busywait, 1'b0);
        tick();
        write = 1'b0; read = 1'b1; address = 8'h06; #1;
        check("whit_readback", readdata, 8'h5A);
        check("whit_rb_busywait", busywait, 1'b0);
        address = 8'h04; #1;
        check("whit_other_byte", readdata, 8'hAA);

        // Conflict miss on dirty line 1 -> write-back then fetch
        address = 8'h25; #1;
        check("dirty_miss_busywait", busywait, 1'b1);
        tick();
        check("wb_write_mem", write_mem, 1'b1);
        check("wb_read_mem", read_mem, 1'b0);
        check("wb_addr", address_mem, 6'h01);
        check("wb_data", writedata_mem, 32'hDD5ABBAA);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
        check("wb2f_write_mem", write_mem, 1'b0);
        check("wb2f_read_mem", read_mem, 1'b1);
        check("wb2f_addr", address_mem, 6'h09);
        readdata_mem = 32'h44332211; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
        check("wb_fill_busywait", busywait, 1'b0);
        check("wb_fill_readdata", readdata, 8'h22);

        // Write miss on clean/invalid line 7
        read = 1'b0; write = 1'b1; address = 8'hFF; writedata = 8'h11; #1;
        check("wmiss_busywait", busywait, 1'b1);
        tick();
        check("wmiss_read_mem", read_mem, 1'b1);
        check("wmiss_write_mem", write_mem, 1'b0);
        check("wmiss_addr", address_mem, 6'h3F);
        readdata_mem = 32'hA0B0C0D0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
        check("wmiss_busy_fall", busywait, 1'b0);
        tick();
        write = 1'b0; read = 1'b1; address = 8'hFF; #1;
        check("wmiss_merged", readdata, 8'h11);
        address = 8'hFC; #1;
        check("wmiss_kept_byte0", readdata, 8'hD0);

        // Evicting line 7 proves it is dirty
        address = 8'h1F; #1;
        tick();
        check("l7_wb_write_mem", write_mem, 1'b1);
        check("l7_wb_addr", address_mem, 6'h3F);
        check("l7_wb_data", writedata_mem, 32'h11B0C0D0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
        check("l7_fetch_read_mem", read_mem, 1'b1);
        check("l7_fetch_addr", address_mem, 6'h07);

        // Reset in the middle of FETCH aborts it
        read = 1'b0; RESET = 1'b0;
        tick();
        check("abort_read_mem", read_mem, 1'b0);
        check("abort_write_mem", write_mem, 1'b0);
        check("abort_address_mem", address_mem, 6'h00);
        check("abort_busywait", busywait, 1'b0);
        RESET = 1'b1;
        read = 1'b1; address = 8'h1F; #1;
        check("abort_line7_miss", busywait, 1'b1);
        address = 8'h25; #1;
        check("abort_line1_miss", busywait, 1'b1);
        tick();
        check("post_rst_clean_fetch", read_mem, 1'b1);
        check("post_rst_no_wb", write_mem, 1'b0);
        check("post_rst_addr", address_mem, 6'h09);
        readdata_mem = 32'h0F0E0D0C; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // Simultaneous read and write on a hit: write wins
        write = 1'b1; read = 1'b1; address = 8'h24; writedata = 8'h77; #1;
        check("rw_busywait", busywait, 1'b0);
        tick();
        write = 1'b0; #1;
        check("rw_write_won", readdata, 8'h77);
        read = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
